// File: rtl/wb_reg_slave_pkg.sv
// Shared types and helpers for the Wishbone register slave.
package wb_reg_slave_pkg;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned MAX_DW = 128;
  localparam int unsigned MAX_NB = MAX_DW / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Word address beyond the register file terminates with err.
  function automatic logic addr_err(input logic [31:0] adr, input logic [31:0] nregs);
    return adr >= nregs;
  endfunction

  // Replace only the byte lanes whose select bit is set.
  function automatic logic [MAX_DW-1:0] byte_merge(input logic [MAX_DW-1:0] old_w,
                                                   input logic [MAX_DW-1:0] new_w,
                                                   input logic [MAX_NB-1:0] sel);
    logic [MAX_DW-1:0] res;
    res = old_w;
    for (int b = 0; b < int'(MAX_NB); b++) begin
      if (sel[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_reg_slave_if.sv
// Wishbone classic bus bundle between an interconnect master port and the register slave.
interface wb_reg_slave_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 3
);
  logic              cyc_i;
  logic              stb_i;
  logic              we_i;
  logic [AW:0]       adr_i;
  logic [DW/8-1:0]   sel_i;
  logic [DW-1:0]     dat_i;
  logic [DW-1:0]     dat_o;
  logic              ack_o;
  logic              err_o;

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    output dat_o, ack_o, err_o
  );

  modport master (
    output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    input  dat_o, ack_o, err_o
  );
endinterface

// File: rtl/wb_reg_slave.sv
// Wishbone classic slave: read-only ID word at offset 0, byte-writable scratch words above it,
// programmable wait states and an error response for addresses past the register file.
module wb_reg_slave
  import wb_reg_slave_pkg::*;
#(
  parameter int unsigned   DW         = 32,
  parameter int unsigned   NREGS      = 8,
  parameter int unsigned   AW         = (NREGS > 2) ? $clog2(NREGS) : 1,
  parameter int unsigned   WAIT       = 0,
  parameter logic [DW-1:0] ID_VALUE   = DW'(32'hc000_0000),
  parameter logic [DW-1:0] INIT_VALUE = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  wb_reg_slave_if.slave  bus
);

  localparam int unsigned NB = DW / 8;

  state_e            r_state;
  state_e            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_req;
  logic              w_latch;
  logic              w_enter_resp;

  logic [AW:0]       r_adr;
  logic              r_we;
  logic [NB-1:0]     r_sel;
  logic [DW-1:0]     r_dat;

  logic              w_from_bus;
  logic [AW:0]       w_adr;
  logic              w_we;
  logic [NB-1:0]     w_sel;
  logic [DW-1:0]     w_dat;
  logic [AW-1:0]     w_idx;
  logic              w_err;
  logic              w_wr;
  logic [DW-1:0]     w_rword;

  logic [DW-1:0]     r_regs [NREGS];
  logic [DW-1:0]     r_rdata;
  logic              r_rerr;

  logic              r_ack;
  logic              r_err;
  logic [DW-1:0]     r_dat_o;

  assign w_req = bus.cyc_i & bus.stb_i;

  // State and wait counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic; a dropped cycle during wait states abandons the request.
  always_comb begin
    w_next       = r_state;
    w_cnt_nxt    = r_cnt;
    w_latch      = 1'b0;
    w_enter_resp = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_latch   = 1'b1;
          w_cnt_nxt = CNT_W'(WAIT);
          if (WAIT > 0) begin
            w_next = ST_WAIT;
          end else begin
            w_next       = ST_RESP;
            w_enter_resp = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (!bus.cyc_i) begin
          w_next    = ST_IDLE;
          w_cnt_nxt = '0;
        end else if (r_cnt == CNT_W'(1)) begin
          w_next       = ST_RESP;
          w_enter_resp = 1'b1;
          w_cnt_nxt    = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Request capture at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_adr <= '0;
      r_we  <= 1'b0;
      r_sel <= '0;
      r_dat <= '0;
    end else if (w_latch) begin
      r_adr <= bus.adr_i;
      r_we  <= bus.we_i;
      r_sel <= bus.sel_i;
      r_dat <= bus.dat_i;
    end
  end

  // With no wait states the commit edge is the acceptance edge, so take the live bus.
  always_comb begin
    w_from_bus = (r_state == ST_IDLE);
    w_adr      = w_from_bus ? bus.adr_i : r_adr;
    w_we       = w_from_bus ? bus.we_i  : r_we;
    w_sel      = w_from_bus ? bus.sel_i : r_sel;
    w_dat      = w_from_bus ? bus.dat_i : r_dat;
    w_idx      = w_adr[AW-1:0];
    w_err      = addr_err(32'(w_adr), 32'(NREGS));
    w_wr       = w_enter_resp & w_we & ~w_err & (w_adr != '0) & (|w_sel);
  end

  always_comb begin
    w_rword = '0;
    if (!w_err) begin
      if (w_adr == '0) w_rword = ID_VALUE;
      else             w_rword = r_regs[w_idx];
    end
  end

  // Scratch words live in flops so each can carry its own reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) r_regs[i] <= INIT_VALUE;
    end else if (w_wr) begin
      r_regs[w_idx] <= DW'(byte_merge(MAX_DW'(r_regs[w_idx]), MAX_DW'(w_dat), MAX_NB'(w_sel)));
    end
  end

  // Read data is sampled alongside the write, so a transaction sees its own pre-write value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
      r_rerr  <= 1'b0;
    end else if (w_enter_resp) begin
      r_rdata <= w_rword;
      r_rerr  <= w_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat_o <= '0;
    end else if (r_state == ST_RESP) begin
      r_ack   <= ~r_rerr;
      r_err   <= r_rerr;
      r_dat_o <= r_rerr ? '0 : r_rdata;
    end else begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat_o <= '0;
    end
  end

  assign bus.ack_o = r_ack;
  assign bus.err_o = r_err;
  assign bus.dat_o = r_dat_o;

endmodule

// File: tb/tb_wb_reg_slave.sv
// Scoreboard bench: two slaves (0 and 3 wait states) driven with directed and random traffic.
module tb_wb_reg_slave;

  localparam int unsigned DW    = 32;
  localparam int unsigned NREGS = 8;
  localparam int unsigned AW    = 3;
  localparam logic [31:0] ID    = 32'hc000_0000;
  localparam logic [31:0] INIT  = 32'h0bad_f00d;

  typedef struct {
    int unsigned cyc;
    bit          err;
    bit          chk_dat;
    logic [31:0] dat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int unsigned cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  logic        d_cyc [2];
  logic        d_stb [2];
  logic        d_we  [2];
  logic [3:0]  d_adr [2];
  logic [3:0]  d_sel [2];
  logic [31:0] d_dat [2];
  logic        m_ack [2];
  logic        m_err [2];
  logic [31:0] m_dat [2];

  wb_reg_slave_if #(.DW(DW), .AW(AW)) if0 ();
  wb_reg_slave_if #(.DW(DW), .AW(AW)) if1 ();

  assign if0.cyc_i = d_cyc[0];
  assign if0.stb_i = d_stb[0];
  assign if0.we_i  = d_we[0];
  assign if0.adr_i = d_adr[0];
  assign if0.sel_i = d_sel[0];
  assign if0.dat_i = d_dat[0];
  assign if1.cyc_i = d_cyc[1];
  assign if1.stb_i = d_stb[1];
  assign if1.we_i  = d_we[1];
  assign if1.adr_i = d_adr[1];
  assign if1.sel_i = d_sel[1];
  assign if1.dat_i = d_dat[1];
  assign m_ack[0] = if0.ack_o;
  assign m_err[0] = if0.err_o;
  assign m_dat[0] = if0.dat_o;
  assign m_ack[1] = if1.ack_o;
  assign m_err[1] = if1.err_o;
  assign m_dat[1] = if1.dat_o;

  wb_reg_slave #(.DW(DW), .NREGS(NREGS), .WAIT(0), .ID_VALUE(ID), .INIT_VALUE(INIT))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  wb_reg_slave #(.DW(DW), .NREGS(NREGS), .WAIT(3), .ID_VALUE(ID), .INIT_VALUE(INIT))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] mdl [2][NREGS];
  int          n_chk = 0;
  int          n_pass = 0;
  int          ack_pulses [2];
  bit          prev_ack [2];

  function automatic int unsigned wt(int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic chk(string nm, int d, logic [31:0] got, logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s dut%0d: got %h want %h (cycle %0d)", nm, d, got, want, cyc_cnt);
  endtask

  function automatic int q_size(int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t q_pop(int d);
    if (d == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic void q_push(int d, exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic void q_clear(int d);
    if (d == 0) q0.delete();
    else        q1.delete();
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < int'(NREGS); i++) mdl[d][i] = INIT;
  endfunction

  // Reference behaviour: expected response for one accepted request, applying any write.
  function automatic exp_t model_txn(int d, bit we, int unsigned adr, logic [3:0] sel,
                                     logic [31:0] dat, int unsigned t);
    exp_t e;
    e.cyc     = t + 1 + wt(d);
    e.err     = (adr >= NREGS);
    e.chk_dat = !we || e.err;
    e.dat     = 32'h0;
    if (!e.err) begin
      if (adr == 0) e.dat = ID;
      else          e.dat = mdl[d][adr];
      if (we && adr != 0)
        for (int b = 0; b < 4; b++)
          if (sel[b]) mdl[d][adr][8*b +: 8] = dat[8*b +: 8];
    end
    return e;
  endfunction

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        logic a, e;
        logic [31:0] dt;
        exp_t x;
        a  = m_ack[d];
        e  = m_err[d];
        dt = m_dat[d];
        if (a || e) begin
          chk("ack_err_excl", d, 32'(a && e), 32'd0);
          if (a) chk("ack_gap", d, 32'(prev_ack[d]), 32'd0);
          chk("resp_expected", d, 32'(q_size(d) != 0), 32'd1);
          if (q_size(d) != 0) begin
            x = q_pop(d);
            chk("resp_cycle", d, cyc_cnt, x.cyc);
            chk("err_o", d, 32'(e), 32'(x.err));
            chk("ack_o", d, 32'(a), 32'(!x.err));
            if (x.chk_dat) chk("dat_o", d, dt, x.dat);
          end
          if (a) ack_pulses[d]++;
        end else begin
          chk("idle_dat", d, dt, 32'h0);
        end
        prev_ack[d] = a;
      end
    end else begin
      prev_ack[0] = 1'b0;
      prev_ack[1] = 1'b0;
    end
  end

  task automatic drive(int d, bit c, bit s, bit we, logic [3:0] adr, logic [3:0] sel,
                       logic [31:0] dat);
    d_cyc[d] = c;
    d_stb[d] = s;
    d_we[d]  = we;
    d_adr[d] = adr;
    d_sel[d] = sel;
    d_dat[d] = dat;
  endtask

  task automatic wait_drain(int d);
    for (int k = 0; k < 40 && q_size(d) != 0; k++) @(negedge clk);
    if (q_size(d) != 0) begin
      chk("timeout", d, 32'(q_size(d)), 32'd0);
      q_clear(d);
    end
  endtask

  task automatic txn(int d, bit we, int unsigned adr, logic [3:0] sel, logic [31:0] dat);
    @(negedge clk);
    drive(d, 1'b1, 1'b1, we, 4'(adr), sel, dat);
    q_push(d, model_txn(d, we, adr, sel, dat, cyc_cnt + 1));
    @(negedge clk);
    d_stb[d] = 1'b0;
    wait_drain(d);
    d_cyc[d] = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    for (int d = 0; d < 2; d++) begin
      chk("rst_ack", d, 32'(m_ack[d]), 32'd0);
      chk("rst_err", d, 32'(m_err[d]), 32'd0);
      chk("rst_dat", d, m_dat[d], 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned t;
    int          p0;
    exp_t        e;

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      drive(d, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
      ack_pulses[d] = 0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;

    // Reset values, ID word and its write protection.
    txn(0, 1'b0, 3, 4'hf, 32'h0);
    txn(0, 1'b0, 0, 4'hf, 32'h0);
    txn(0, 1'b1, 0, 4'hf, 32'hffff_ffff);
    txn(0, 1'b0, 0, 4'hf, 32'h0);

    // Byte-lane write with wait states.
    txn(1, 1'b1, 2, 4'hf, 32'haabb_ccdd);
    txn(1, 1'b1, 2, 4'b0101, 32'h1234_5678);
    txn(1, 1'b0, 2, 4'hf, 32'h0);
    txn(0, 1'b1, 5, 4'h0, 32'h1111_2222);

    // Out-of-range decode on both slaves, then full readback.
    for (int d = 0; d < 2; d++) begin
      txn(d, 1'b0, NREGS, 4'hf, 32'h0);
      txn(d, 1'b1, NREGS, 4'hf, 32'hdead_beef);
      for (int a = 0; a < int'(NREGS); a++) txn(d, 1'b0, a, 4'hf, 32'h0);
    end

    // Master abandons a write after one wait cycle.
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 1'b1, 4'd4, 4'hf, 32'h5555_aaaa);
    @(negedge clk);
    d_stb[1] = 1'b0;
    @(negedge clk);
    d_cyc[1] = 1'b0;
    repeat (8) @(negedge clk);
    txn(1, 1'b0, 4, 4'hf, 32'h0);

    // Reset lands during the wait states of a pending write.
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 1'b1, 4'd2, 4'hf, 32'h7777_8888);
    @(negedge clk);
    d_stb[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    model_reset();
    q_clear(0);
    q_clear(1);
    d_cyc[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    txn(1, 1'b0, 2, 4'hf, 32'h0);
    txn(0, 1'b0, 2, 4'hf, 32'h0);

    // Strobe held for ten sampled edges with no wait states.
    txn(0, 1'b1, 1, 4'hf, 32'h0102_0304);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 1'b0, 4'd1, 4'hf, 32'h0);
    t  = cyc_cnt + 1;
    p0 = ack_pulses[0];
    for (int k = 0; k < 5; k++) begin
      e = model_txn(0, 1'b0, 1, 4'hf, 32'h0, t + 2 * k);
      q_push(0, e);
    end
    repeat (10) @(negedge clk);
    d_stb[0] = 1'b0;
    wait_drain(0);
    d_cyc[0] = 1'b0;
    chk("pulse_count", 0, 32'(ack_pulses[0] - p0), 32'd5);

    // Random traffic across both slaves, including error addresses.
    for (int n = 0; n < 40; n++) begin
      txn($urandom_range(0, 1), 1'($urandom_range(0, 1)), $urandom_range(0, 9),
          4'($urandom), $urandom);
    end
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < int'(NREGS); a++) txn(d, 1'b0, a, 4'hf, 32'h0);

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
